avg_window: RTL and testbench

- Parametrised moving-average filter; the successor to the fixed 8-sample, 8-bit averager.
- Keeps a circular window of the last DEPTH = 2^LOG2_DEPTH samples and a running sum.
- Emits the window mean one cycle after each accepted sample.
- Adds what the fixed version lacks: input qualifier, output valid, window-full flag, synchronous flush, and selectable rounding.

---
 rtl/avg_pkg.sv | 23 ++
 rtl/avg_window_if.sv | 27 ++
 rtl/avg_ring_buf.sv | 49 ++++
 rtl/avg_window.sv | 81 ++++++++
 tb/tb_avg_window.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/avg_pkg.sv
// Shared widths, rounding constant and default parameters for the moving-average filter.
package avg_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_LOG2_DEPTH = 3;
  localparam int DEF_ROUND      = 0;

  // Running sum of DEPTH samples of DATA_W bits.
  function automatic int sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  // Half of the divisor when rounding half-up; nothing to add for a window of one.
  function automatic int round_const(input int log2_depth, input int round);
    return (round != 0 && log2_depth > 0) ? (1 << (log2_depth - 1)) : 0;
  endfunction

  // Pointer width, kept at least one bit so a single-entry window still elaborates.
  function automatic int ptr_w(input int log2_depth);
    return (log2_depth > 0) ? log2_depth : 1;
  endfunction

endpackage

// File: rtl/avg_window_if.sv
// Sample/result bundle of the moving-average filter; master drives samples, slave is the filter.
interface avg_window_if #(
  parameter int DATA_W     = avg_pkg::DEF_DATA_W,
  parameter int LOG2_DEPTH = avg_pkg::DEF_LOG2_DEPTH
);

  localparam int SUM_W = avg_pkg::sum_w(DATA_W, LOG2_DEPTH);

  logic              in_valid;
  logic [DATA_W-1:0] num_in;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] avg_out;
  logic              win_full;
  logic [SUM_W-1:0]  sum_out;

  modport master (
    output in_valid, num_in, flush,
    input  out_valid, avg_out, win_full, sum_out
  );

  modport slave (
    input  in_valid, num_in, flush,
    output out_valid, avg_out, win_full, sum_out
  );

endinterface

// File: rtl/avg_ring_buf.sv
// Circular window of the last DEPTH samples; exposes the slot about to be overwritten.
module avg_ring_buf
  import avg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic              clk,
  input  logic              rs,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] oldest
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int PTR_W = ptr_w(LOG2_DEPTH);

  logic [DATA_W-1:0] win_q [DEPTH];
  logic [DATA_W-1:0] win_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  assign oldest = win_q[ptr_q];

  always_comb begin
    // NOTE: every output of this block is given its hold value first, so no path leaves one unassigned and infers a latch.
    win_d = win_q;
    ptr_d = ptr_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
      ptr_d = '0;
    end else if (wr_en) begin
      win_d[ptr_q] = wr_data;
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      // NOTE: the window array is reset on purpose: empty slots must read as 0 because the partial-window mean counts them.
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      win_q <= win_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/avg_window.sv
// Moving-average filter: running sum over a 2^LOG2_DEPTH window, mean registered one cycle after each sample.
module avg_window
  import avg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int ROUND      = DEF_ROUND
) (
  input logic        clk,
  input logic        rs,
  avg_window_if.slave bus
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = sum_w(DATA_W, LOG2_DEPTH);
  localparam int FILL_W = LOG2_DEPTH + 1;
  localparam int RND    = round_const(LOG2_DEPTH, ROUND);

  logic              accept;
  logic [DATA_W-1:0] oldest;
  logic [SUM_W-1:0]  sum_next, sum_rnd;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              out_valid_q, out_valid_d;

  assign accept = bus.in_valid & ~bus.flush;

  avg_ring_buf #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .rs      (rs),
    .clear   (bus.flush),
    .wr_en   (accept),
    .wr_data (bus.num_in),
    .oldest  (oldest)
  );

  // The evicted sample is already in the sum, so the subtraction never underflows.
  assign sum_next = sum_q + SUM_W'(bus.num_in) - SUM_W'(oldest);
  assign sum_rnd  = sum_next + SUM_W'(RND);

  always_comb begin
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    out_valid_d = 1'b0;
    if (bus.flush) begin
      sum_d  = '0;
      fill_d = '0;
      avg_d  = '0;
    end else if (accept) begin
      sum_d       = sum_next;
      avg_d       = DATA_W'(sum_rnd >> LOG2_DEPTH);
      out_valid_d = 1'b1;
      if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.avg_out   = avg_q;
  assign bus.sum_out   = sum_q;
  assign bus.win_full  = (fill_q == FILL_W'(DEPTH));

endmodule

// File: tb/tb_avg_window.sv
// Bench for avg_window: truncating and rounding 8x8 filters side by side against a scoreboard, plus a 4x12 filter.
module tb_avg_window;
  import avg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rs, rs_c;

  avg_window_if #(.DATA_W(8),  .LOG2_DEPTH(3)) if_a ();
  avg_window_if #(.DATA_W(8),  .LOG2_DEPTH(3)) if_b ();
  avg_window_if #(.DATA_W(12), .LOG2_DEPTH(2)) if_c ();

  avg_window #(.DATA_W(8),  .LOG2_DEPTH(3), .ROUND(0)) dut_a (.clk(clk), .rs(rs),   .bus(if_a.slave));
  avg_window #(.DATA_W(8),  .LOG2_DEPTH(3), .ROUND(1)) dut_b (.clk(clk), .rs(rs),   .bus(if_b.slave));
  avg_window #(.DATA_W(12), .LOG2_DEPTH(2), .ROUND(0)) dut_c (.clk(clk), .rs(rs_c), .bus(if_c.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int avg_t;
    int avg_r;
    int sum;
    bit full;
  } exp_t;

  exp_t sb[$];
  int   m_win[8];
  int   m_sum, m_ptr, m_fill;
  int   last_t, last_r;
  int   pulses;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_win[i] = 0;
    m_sum  = 0;
    m_ptr  = 0;
    m_fill = 0;
    last_t = 0;
    last_r = 0;
  endtask

  // One cycle on the 8-sample pair: drive, update model, wait an edge, compare.
  task automatic step(input bit r, input bit f, input bit v, input int d);
    bit   exp_v;
    exp_t e;
    rs = r;
    if_a.flush = f; if_a.in_valid = v; if_a.num_in = 8'(d);
    if_b.flush = f; if_b.in_valid = v; if_b.num_in = 8'(d);
    exp_v = !r && !f && v;
    if (r || f) begin
      model_clear();
    end else if (v) begin
      m_sum = m_sum + d - m_win[m_ptr];
      m_win[m_ptr] = d;
      m_ptr = (m_ptr + 1) % 8;
      if (m_fill < 8) m_fill++;
      last_t = m_sum / 8;
      last_r = (m_sum + 4) / 8;
      sb.push_back('{last_t, last_r, m_sum, m_fill == 8});
    end
    @(posedge clk);
    #1;
    check("out_valid_a", if_a.out_valid, exp_v);
    check("out_valid_b", if_b.out_valid, exp_v);
    if (if_a.out_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("avg_trunc", if_a.avg_out, e.avg_t);
        check("avg_round", if_b.avg_out, e.avg_r);
        check("sum_a", if_a.sum_out, e.sum);
        check("sum_b", if_b.sum_out, e.sum);
        check("full_a", if_a.win_full, e.full);
        check("full_b", if_b.win_full, e.full);
      end
    end else begin
      check("hold_avg_a", if_a.avg_out, last_t);
      check("hold_avg_b", if_b.avg_out, last_r);
      check("hold_sum_a", if_a.sum_out, m_sum);
      check("hold_full_a", if_a.win_full, m_fill == 8);
    end
  endtask

  task automatic step_c(input bit r, input bit v, input int d);
    rs_c = r;
    if_c.flush    = 1'b0;
    if_c.in_valid = v;
    if_c.num_in   = 12'(d);
    @(posedge clk);
    #1;
  endtask

  int seq8 [8] = '{100, 20, 55, 80, 70, 120, 40, 10};

  initial begin
    model_clear();
    pulses = 0;
    rs = 1'b1;
    if_a.flush = 0; if_a.in_valid = 0; if_a.num_in = 0;
    if_b.flush = 0; if_b.in_valid = 0; if_b.num_in = 0;
    rs_c = 1'b1;
    if_c.flush = 0; if_c.in_valid = 0; if_c.num_in = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_avg", if_a.avg_out, 0);
    check("rst_sum", if_a.sum_out, 0);
    check("rst_full", if_a.win_full, 0);

    step(0, 0, 1, 100);
    check("one_avg_t", if_a.avg_out, 12);
    check("one_avg_r", if_b.avg_out, 13);
    check("one_sum", if_a.sum_out, 100);
    check("one_full", if_a.win_full, 0);

    step(1, 0, 0, 0);
    foreach (seq8[i]) step(0, 0, 1, seq8[i]);
    check("seq_sum", if_a.sum_out, 495);
    check("seq_avg_t", if_a.avg_out, 61);
    check("seq_avg_r", if_b.avg_out, 62);
    check("seq_full", if_a.win_full, 1);
    step(0, 0, 1, 200);
    check("wrap_sum", if_a.sum_out, 595);
    check("wrap_avg_t", if_a.avg_out, 74);
    check("wrap_avg_r", if_b.avg_out, 74);

    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 1, 255);
    check("max_avg_t", if_a.avg_out, 255);
    check("max_avg_r", if_b.avg_out, 255);
    check("max_sum", if_b.sum_out, 2040);

    step(1, 0, 0, 0);
    pulses = 0;
    step(0, 0, 1, 200);
    repeat (3) step(0, 0, 0, 0);
    check("gap_hold_avg", if_a.avg_out, 25);
    step(0, 0, 1, 100);
    check("gap_pulses", pulses, 2);
    check("gap_sum", if_a.sum_out, 300);

    for (int i = 1; i <= 6; i++) step(0, 0, 1, 10 * i);
    check("pre_flush_full", if_a.win_full, 1);
    step(0, 1, 1, 50);
    check("flush_sum", if_a.sum_out, 0);
    check("flush_avg", if_a.avg_out, 0);
    check("flush_full", if_a.win_full, 0);
    check("flush_nvalid", if_b.out_valid, 0);
    step(0, 0, 1, 80);
    check("post_flush_avg_t", if_a.avg_out, 10);
    check("post_flush_avg_r", if_b.avg_out, 10);

    for (int i = 0; i < 5; i++) step(0, 0, 1, 30 + i);
    step(1, 0, 1, 99);
    check("mid_rst_sum", if_a.sum_out, 0);
    check("mid_rst_avg", if_b.avg_out, 0);
    check("mid_rst_valid", if_a.out_valid, 0);
    step(0, 0, 1, 100);
    check("refill_avg_t", if_a.avg_out, 12);
    check("refill_avg_r", if_b.avg_out, 13);

    repeat (400) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
    end
    check("sb_drained", sb.size(), 0);

    step_c(1, 0, 0);
    check("c_rst_avg", if_c.avg_out, 0);
    check("c_rst_sum", if_c.sum_out, 0);
    step_c(0, 1, 4095);
    check("c_one_avg", if_c.avg_out, 1023);
    step_c(0, 1, 4095);
    step_c(0, 1, 4095);
    check("c_three_sum", if_c.sum_out, 12285);
    check("c_three_avg", if_c.avg_out, 3071);
    check("c_three_full", if_c.win_full, 0);
    step_c(0, 1, 4095);
    check("c_full_avg", if_c.avg_out, 4095);
    check("c_full_sum", if_c.sum_out, 16380);
    check("c_full_full", if_c.win_full, 1);
    step_c(0, 1, 7);
    check("c_wrap_sum", if_c.sum_out, 12292);
    step_c(1, 1, 4095);
    check("c_mid_rst_sum", if_c.sum_out, 0);
    check("c_mid_rst_full", if_c.win_full, 0);
    check("c_mid_rst_valid", if_c.out_valid, 0);
    repeat (4) step_c(0, 1, 4095);
    check("c_refill_avg", if_c.avg_out, 4095);
    check("c_refill_full", if_c.win_full, 1);
    step_c(0, 0, 0);
    check("c_idle_valid", if_c.out_valid, 0);
    check("c_idle_hold", if_c.avg_out, 4095);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
